// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB3 requester:
//   - apb_state_e   : requester FSM states (IDLE, SETUP, ACCESS)
//   - CMD_*         : command encodings on add_i (2'b10 is reserved, acts as NOP)
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - is_xfer_cmd() : true for the two encodings that start a transfer
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  function automatic logic is_xfer_cmd(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB3 requester: accepts single-word READ/WRITE commands while idle and runs
// the IDLE -> SETUP -> ACCESS handshake on the slave bus, honouring wait
// states and pslverr. Returns read data, a one-cycle done pulse and an error
// flag to the command source.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without pready_i (done_o + err_o + timeout_o).
// Without the macro the ACCESS phase waits indefinitely and timeout_o is 0.
//
// Ports
//   pclk, preset_n            clock, asynchronous active-low reset
//   add_i, addr_i, wdata_i    command, address, write data (sampled in IDLE)
//   cmd_ready_o               high in IDLE: a command is accepted this cycle
//   psel_o .. pwdata_o        APB requester outputs
//   prdata_i, pready_i,
//   pslverr_i                 APB slave responses
//   rdata_o                   data of the last completed READ
//   done_o, err_o, timeout_o  completion pulse and status (valid with done_o)
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [1:0]        add_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              cmd_ready_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              err_q;
  logic              timeout_q;

  logic cmd_go;
  logic xfer_done;
  logic timeout_hit;

  assign cmd_go    = (state_q == IDLE) && is_xfer_cmd(add_i);
  // pslverr_i only matters on the completing edge of ACCESS.
  assign xfer_done = (state_q == ACCESS) && pready_i;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Abort only when the slave is still stalling with the counter at the
  // limit; pready_i on that same cycle wins and completes normally.
  assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready_i && !timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_go) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Bus address/direction/data are captured once per command and held
      // through IDLE so the bus does not toggle between transfers.
      if (cmd_go) begin
        addr_q  <= addr_i;
        write_q <= (add_i == CMD_WRITE);
        if (add_i == CMD_WRITE) begin
          wdata_q <= wdata_i;
        end
      end
      if (xfer_done && !write_q) begin
        rdata_q <= prdata_i;
      end
      done_q    <= xfer_done || timeout_hit;
      err_q     <= (xfer_done && pslverr_i) || timeout_hit;
      timeout_q <= timeout_hit;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master. Each test task drives one scenario and
// compares DUT outputs against hand-computed values. With APB_TIMEOUT_EN the
// DUT is built with TIMEOUT_CYCLES=4 and the timeout scenarios are exercised;
// otherwise a long stall checks that the requester simply keeps waiting.
// ---------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

`ifdef APB_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 16;
`endif

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  add_i;
  logic [31:0] addr_i, wdata_i, prdata_i;
  logic        pready_i, pslverr_i;
  logic        cmd_ready_o, psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, rdata_o;
  logic        done_o, err_o, timeout_o;

  int vectors = 0;
  int miscompares = 0;

  // Results recorded by xfer() for the calling test to check.
  int          r_psel, r_pen, r_done;
  logic        r_err, r_to, r_ready, r_stable, r_first_setup;
  logic [31:0] r_rdata;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .pclk(pclk), .preset_n(preset_n), .add_i(add_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .cmd_ready_o(cmd_ready_o), .psel_o(psel_o),
    .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .rdata_o(rdata_o), .done_o(done_o),
    .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command (accepted at the next rising edge) and act as a slave
  // that raises pready_i after nwait ACCESS cycles. Returns at the falling
  // edge of the done cycle, or after 40 cycles without done.
  task automatic xfer(input logic [1:0] cmd, input logic [31:0] a,
                      input logic [31:0] wd, input int nwait,
                      input logic slverr, input logic [31:0] rd);
    add_i = cmd; addr_i = a; wdata_i = wd; prdata_i = rd;
    r_psel = 0; r_pen = 0; r_done = 0; r_stable = 1'b1; r_first_setup = 1'b0;
    r_err = 1'b0; r_to = 1'b0; r_ready = 1'b0; r_rdata = '0;
    @(posedge pclk); #1;
    add_i = CMD_NOP;
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk);
      if (k == 1) r_first_setup = psel_o && !penable_o;
      if (psel_o) begin
        r_psel++;
        if (paddr_o !== a || pwrite_o !== (cmd == CMD_WRITE) ||
            (cmd == CMD_WRITE && pwdata_o !== wd)) r_stable = 1'b0;
      end
      if (penable_o) begin
        r_pen++;
        pready_i  = (r_pen > nwait);
        pslverr_i = pready_i & slverr;
      end else begin
        pready_i = 1'b0; pslverr_i = 1'b0;
      end
      if (done_o) begin
        r_done = k; r_err = err_o; r_to = timeout_o;
        r_rdata = rdata_o; r_ready = cmd_ready_o;
        pready_i = 1'b0; pslverr_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0; add_i = CMD_NOP; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    vectors++;
    if ({psel_o, penable_o, done_o, err_o, timeout_o, cmd_ready_o} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got psel/pen/done/err/to/rdy=%b want 000001",
               {psel_o, penable_o, done_o, err_o, timeout_o, cmd_ready_o});
    end
    vectors++;
    if (paddr_o !== 32'h0 || pwdata_o !== 32'h0 || rdata_o !== 32'h0 || pwrite_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h pwrite=%b want all 0",
               paddr_o, pwdata_o, rdata_o, pwrite_o);
    end
    preset_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_read_one_wait();
    xfer(CMD_READ, 32'h10, 32'h0, 1, 1'b0, 32'h1F);
    $display("read  addr=10 wait=1: psel=%0d pen=%0d done@%0d rdata=%h err=%b",
             r_psel, r_pen, r_done, r_rdata, r_err);
    vectors++;
    if (r_psel != 3 || r_pen != 2 || r_done != 4) begin
      miscompares++;
      $display("FAIL read_timing: got psel=%0d pen=%0d done@%0d want 3 2 4", r_psel, r_pen, r_done);
    end
    vectors++;
    if (r_rdata !== 32'h1F || r_err !== 1'b0 || r_to !== 1'b0 || r_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL read_result: got rdata=%h err=%b to=%b rdy=%b want 1f 0 0 1",
               r_rdata, r_err, r_to, r_ready);
    end
    vectors++;
    if (r_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL read_bus_stable: got %b want 1", r_stable);
    end
    @(negedge pclk);
  endtask

  task automatic test_write_zero_wait();
    xfer(CMD_WRITE, 32'h20, 32'hDEADBEEF, 0, 1'b0, 32'h55555555);
    $display("write addr=20 data=deadbeef wait=0: psel=%0d pen=%0d done@%0d",
             r_psel, r_pen, r_done);
    vectors++;
    if (r_psel != 2 || r_pen != 1 || r_done != 3) begin
      miscompares++;
      $display("FAIL write_timing: got psel=%0d pen=%0d done@%0d want 2 1 3", r_psel, r_pen, r_done);
    end
    vectors++;
    if (r_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL write_bus_stable: got %b want 1", r_stable);
    end
    vectors++;
    if (r_rdata !== 32'h1F || r_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_keeps_rdata: got rdata=%h err=%b want 1f 0", r_rdata, r_err);
    end
    @(negedge pclk);
    vectors++;
    if (pwdata_o !== 32'hDEADBEEF || paddr_o !== 32'h20 || pwrite_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got paddr=%h pwdata=%h pwrite=%b done=%b want 20 deadbeef 1 0",
               paddr_o, pwdata_o, pwrite_o, done_o);
    end
  endtask

  task automatic test_read_slverr();
    xfer(CMD_READ, 32'h40, 32'h0, 3, 1'b1, 32'hA5A50003);
    $display("read  addr=40 wait=3 slverr: pen=%0d done@%0d rdata=%h err=%b",
             r_pen, r_done, r_rdata, r_err);
    vectors++;
    if (r_pen != 4 || r_done != 6) begin
      miscompares++;
      $display("FAIL slverr_timing: got pen=%0d done@%0d want 4 6", r_pen, r_done);
    end
    vectors++;
    if (r_err !== 1'b1 || r_to !== 1'b0 || r_rdata !== 32'hA5A50003) begin
      miscompares++;
      $display("FAIL slverr_result: got err=%b to=%b rdata=%h want 1 0 a5a50003", r_err, r_to, r_rdata);
    end
    @(negedge pclk);
  endtask

  task automatic test_back_to_back();
    xfer(CMD_WRITE, 32'h30, 32'h12345678, 0, 1'b0, 32'h0);
    vectors++;
    if (r_done != 3 || r_ready !== 1'b1 || r_rdata !== 32'hA5A50003) begin
      miscompares++;
      $display("FAIL b2b_first: got done@%0d rdy=%b rdata=%h want 3 1 a5a50003", r_done, r_ready, r_rdata);
    end
    // Issued from inside the done cycle: must be accepted at the next edge.
    xfer(CMD_READ, 32'h34, 32'h0, 0, 1'b0, 32'hCAFE0001);
    $display("b2b   write 30 then read 34: second setup=%b done@%0d rdata=%h",
             r_first_setup, r_done, r_rdata);
    vectors++;
    if (r_first_setup !== 1'b1 || r_done != 3 || r_rdata !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL b2b_second: got setup=%b done@%0d rdata=%h want 1 3 cafe0001",
               r_first_setup, r_done, r_rdata);
    end
    @(negedge pclk);
  endtask

  task automatic test_reserved_cmd();
    add_i = 2'b10; addr_i = 32'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      vectors++;
      if (psel_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reserved_nop[%0d]: got psel=%b rdy=%b want 0 1", k, psel_o, cmd_ready_o);
      end
    end
    $display("cmd 10 for 3 cycles: psel=%b paddr=%h", psel_o, paddr_o);
    add_i = CMD_NOP;
  endtask

  task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
    xfer(CMD_READ, 32'h60, 32'h0, 100, 1'b0, 32'h77777777);
    $display("read  addr=60 stuck: pen=%0d done@%0d err=%b to=%b", r_pen, r_done, r_err, r_to);
    vectors++;
    if (r_pen != 5 || r_done != 7) begin
      miscompares++;
      $display("FAIL timeout_timing: got pen=%0d done@%0d want 5 7", r_pen, r_done);
    end
    vectors++;
    if (r_err !== 1'b1 || r_to !== 1'b1 || r_rdata !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL timeout_result: got err=%b to=%b rdata=%h want 1 1 cafe0001", r_err, r_to, r_rdata);
    end
    @(negedge pclk);
    xfer(CMD_READ, 32'h64, 32'h0, 4, 1'b0, 32'h0BADF00D);
    $display("read  addr=64 ready on limit: pen=%0d done@%0d to=%b", r_pen, r_done, r_to);
    vectors++;
    if (r_done != 7 || r_err !== 1'b0 || r_to !== 1'b0 || r_rdata !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL timeout_limit_ready: got done@%0d err=%b to=%b rdata=%h want 7 0 0 0badf00d",
               r_done, r_err, r_to, r_rdata);
    end
`else
    xfer(CMD_READ, 32'h60, 32'h0, 20, 1'b0, 32'h0BADF00D);
    $display("read  addr=60 wait=20: pen=%0d done@%0d to=%b", r_pen, r_done, r_to);
    vectors++;
    if (r_pen != 21 || r_done != 23 || r_to !== 1'b0 || r_err !== 1'b0 || r_rdata !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL long_wait: got pen=%0d done@%0d to=%b err=%b rdata=%h want 21 23 0 0 0badf00d",
               r_pen, r_done, r_to, r_err, r_rdata);
    end
`endif
    @(negedge pclk);
  endtask

  task automatic test_reset_mid_transfer();
    logic saw_done;
    add_i = CMD_READ; addr_i = 32'h50; prdata_i = 32'h13572468;
    @(posedge pclk); #1; add_i = CMD_NOP;
    @(posedge pclk); #1;
    vectors++;
    if (penable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_access: got penable=%b want 1", penable_o);
    end
    #2 preset_n = 1'b0;
    #1;
    vectors++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || cmd_ready_o !== 1'b1 || rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got psel=%b pen=%b rdy=%b rdata=%h want 0 0 1 0",
               psel_o, penable_o, cmd_ready_o, rdata_o);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    pready_i = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      if (done_o !== 1'b0 || psel_o !== 1'b0) saw_done = 1'b1;
    end
    pready_i = 1'b0;
    $display("reset in ACCESS: activity after release=%b", saw_done);
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_no_done: got activity=%b want 0", saw_done);
    end
  endtask

  initial begin
    test_reset();
    test_read_one_wait();
    test_write_zero_wait();
    test_read_slverr();
    test_back_to_back();
    test_reserved_cmd();
    test_timeout();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
